// File: rtl/serial_sub_4bit.sv
// serial_sub_4bit: bit-serial two's-complement subtractor, DIFF = X - Y - B_IN.
// One full-subtractor cell plus a borrow flop, one bit per clock, LSB first.
// A START/DONE handshake lets a front-end FSM launch operations and collect results.
// Optional feature macro: SERIAL_SUB_OVF_EN adds a registered signed-overflow output V.
module serial_sub_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             B_IN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] DIFF,
  output logic             B_OUT
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             V
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Full-subtractor difference bit.
  function automatic logic fs_diff(input logic a, input logic b, input logic bi);
    return a ^ b ^ bi;
  endfunction

  // Full-subtractor borrow-out: borrow when a < b + bi.
  function automatic logic fs_borrow(input logic a, input logic b, input logic bi);
    return (~a & b) | (~(a ^ b) & bi);
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] xs_q, xs_d;
  logic [WIDTH-1:0] ys_q, ys_d;
  logic [WIDTH-1:0] rs_q, rs_d;
  logic             bf_q, bf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             done_q, done_d;
  logic             d_bit;
  logic             b_next;
`ifdef SERIAL_SUB_OVF_EN
  logic             xm_q, xm_d;
  logic             ym_q, ym_d;
  logic             v_q, v_d;
`endif

  assign d_bit  = fs_diff(xs_q[0], ys_q[0], bf_q);
  assign b_next = fs_borrow(xs_q[0], ys_q[0], bf_q);

  assign BUSY  = (state_q == SHIFT);
  assign DONE  = done_q;
  assign DIFF  = diff_q;
  assign B_OUT = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign V     = v_q;
`endif

  // Next-state and datapath: latch operands on START, then shift one bit per clock.
  always_comb begin
    state_d = state_q;
    xs_d    = xs_q;
    ys_d    = ys_q;
    rs_d    = rs_q;
    bf_d    = bf_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    done_d  = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
    xm_d    = xm_q;
    ym_d    = ym_q;
    v_d     = v_q;
`endif
    case (state_q)
      IDLE: begin
        if (START) begin
          xs_d    = X;
          ys_d    = Y;
          bf_d    = B_IN;
          cnt_d   = '0;
          state_d = SHIFT;
`ifdef SERIAL_SUB_OVF_EN
          // Operand sign bits survive here because xs/ys are consumed by shifting.
          xm_d    = X[WIDTH-1];
          ym_d    = Y[WIDTH-1];
`endif
        end
      end
      SHIFT: begin
        xs_d  = {1'b0, xs_q[WIDTH-1:1]};
        ys_d  = {1'b0, ys_q[WIDTH-1:1]};
        rs_d  = {d_bit, rs_q[WIDTH-1:1]};
        bf_d  = b_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          // Last bit: rs_d already holds the full difference.
          diff_d  = rs_d;
          bout_d  = b_next;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
`ifdef SERIAL_SUB_OVF_EN
          v_d     = (xm_q ^ ym_q) & (d_bit ^ xm_q);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything and aborts any operation.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      xs_q    <= '0;
      ys_q    <= '0;
      rs_q    <= '0;
      bf_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      xm_q    <= 1'b0;
      ym_q    <= 1'b0;
      v_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      xs_q    <= xs_d;
      ys_q    <= ys_d;
      rs_q    <= rs_d;
      bf_q    <= bf_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      done_q  <= done_d;
`ifdef SERIAL_SUB_OVF_EN
      xm_q    <= xm_d;
      ym_q    <= ym_d;
      v_q     <= v_d;
`endif
    end
  end

endmodule
